// File: rtl/ram8_arbiter_pkg.sv
// Shared widths, FSM states and requester-select encoding for the RAM8 arbiter.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package ram8_arbiter_pkg;

   localparam int DW    = 16;
   localparam int AW    = 3;
   localparam int DEPTH = 8;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   typedef enum logic {
      SEL_A = 1'b0,
      SEL_B = 1'b1
   } sel_t;

endpackage

// File: rtl/ram8_arbiter_ram8.sv
// RAM8: 8 x 16-bit word store, synchronous write, combinational read.
// Latency: write lands at the rising edge with load=1; out follows address immediately.
// Backpressure: none, accepts one write per cycle.
// Ports: in (write data), load (write enable), address (word select), clk, out (read data).
module ram8
   import ram8_arbiter_pkg::*;
(
   input  logic [DW-1:0] in,
   input  logic          load,
   input  logic [AW-1:0] address,
   input  logic          clk,
   output logic [DW-1:0] out
);

   logic [DW-1:0] r_mem [DEPTH];

   // Contents have no reset; they become defined through the arbiter's fill.
   always_ff @(posedge clk) begin
      if (load) begin
         r_mem[address] <= in;
      end
   end

   assign out = r_mem[address];

endmodule

// File: rtl/ram8_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RAM8, with post-reset fill.
// Latency: grant is combinational; read data is registered, rvalid one cycle after grant.
// Backpressure: a loser sees gnt=0 and must hold its request; no grants while busy.
// Ports: clk, rst_n; per requester x in {a,b}: x_req, x_we, x_addr, x_wdata in,
//        x_gnt, x_rvalid, x_rdata out; busy out (fill in progress).
module ram8_arbiter
   import ram8_arbiter_pkg::*;
#(
   parameter int             CLEAR_ON_RESET = 1,
   parameter logic [DW-1:0]  CLEAR_VAL      = 16'd0
)
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          a_req,
   input  logic          a_we,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_wdata,
   output logic          a_gnt,
   output logic          a_rvalid,
   output logic [DW-1:0] a_rdata,
   input  logic          b_req,
   input  logic          b_we,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_wdata,
   output logic          b_gnt,
   output logic          b_rvalid,
   output logic [DW-1:0] b_rdata,
   output logic          busy
);

   state_t        r_state;
   logic [AW-1:0] r_cnt;
   logic          r_busy;
   sel_t          r_ptr;
   logic [AW-1:0] r_addr;
   logic          r_a_rvalid;
   logic          r_b_rvalid;
   logic [DW-1:0] r_a_rdata;
   logic [DW-1:0] r_b_rdata;

   logic          w_a_win;
   logic          w_b_win;
   logic [DW-1:0] w_ram_in;
   logic          w_ram_load;
   logic [AW-1:0] w_ram_addr;
   logic [DW-1:0] w_ram_out;

   // A lone requester always wins; on contention the pointer decides.
   // Grants are also masked by rst_n so they read 0 while reset is held.
   always_comb begin
      w_a_win = 1'b0;
      w_b_win = 1'b0;
      if (rst_n && (r_state == ST_RUN)) begin
         w_a_win = a_req && (!b_req || (r_ptr == SEL_A));
         w_b_win = b_req && (!a_req || (r_ptr == SEL_B));
      end
   end

   // RAM port mux. With no access the address is parked on its last value.
   always_comb begin
      w_ram_in   = CLEAR_VAL;
      w_ram_load = 1'b0;
      w_ram_addr = r_addr;
      if (r_state == ST_INIT) begin
         w_ram_in   = CLEAR_VAL;
         w_ram_load = 1'b1;
         w_ram_addr = r_cnt;
      end else if (w_a_win) begin
         w_ram_in   = a_wdata;
         w_ram_load = a_we;
         w_ram_addr = a_addr;
      end else if (w_b_win) begin
         w_ram_in   = b_wdata;
         w_ram_load = b_we;
         w_ram_addr = b_addr;
      end
   end

   ram8 u_ram (
      .in      (w_ram_in),
      .load    (w_ram_load),
      .address (w_ram_addr),
      .clk     (clk),
      .out     (w_ram_out)
   );

   // Fill FSM: one word per cycle from address 0, then hand over to arbitration.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
         r_cnt   <= '0;
         r_busy  <= (CLEAR_ON_RESET != 0);
      end else begin
         case (r_state)
            ST_INIT: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == AW'(DEPTH - 1)) begin
                  r_state <= ST_RUN;
                  r_busy  <= 1'b0;
               end
            end
            ST_RUN: begin
               r_busy <= 1'b0;
            end
            default: begin
               r_state <= ST_RUN;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Pointer, parked address and read-data capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr      <= SEL_A;
         r_addr     <= '0;
         r_a_rvalid <= 1'b0;
         r_b_rvalid <= 1'b0;
         r_a_rdata  <= '0;
         r_b_rdata  <= '0;
      end else begin
         r_addr     <= w_ram_addr;
         r_a_rvalid <= w_a_win && !a_we;
         r_b_rvalid <= w_b_win && !b_we;
         if (w_a_win && !a_we) begin
            r_a_rdata <= w_ram_out;
         end
         if (w_b_win && !b_we) begin
            r_b_rdata <= w_ram_out;
         end
         // The pointer always moves away from whoever was just served.
         if (w_a_win) begin
            r_ptr <= SEL_B;
         end else if (w_b_win) begin
            r_ptr <= SEL_A;
         end
      end
   end

   assign a_gnt    = w_a_win;
   assign b_gnt    = w_b_win;
   assign a_rvalid = r_a_rvalid;
   assign b_rvalid = r_b_rvalid;
   assign a_rdata  = r_a_rdata;
   assign b_rdata  = r_b_rdata;
   assign busy     = r_busy;

endmodule

// File: tb/tb_ram8_arbiter.sv
// Bench for ram8_arbiter: directed scenarios, a contention table and random traffic
// checked against a simple memory/pointer model.
module tb_ram8_arbiter;

   logic        clk;
   logic        rst_n;
   logic        a_req, a_we, b_req, b_we;
   logic [2:0]  a_addr, b_addr;
   logic [15:0] a_wdata, b_wdata;
   logic        a_gnt, a_rvalid, b_gnt, b_rvalid, busy;
   logic [15:0] a_rdata, b_rdata;

   ram8_arbiter dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .a_req    (a_req),
      .a_we     (a_we),
      .a_addr   (a_addr),
      .a_wdata  (a_wdata),
      .a_gnt    (a_gnt),
      .a_rvalid (a_rvalid),
      .a_rdata  (a_rdata),
      .b_req    (b_req),
      .b_we     (b_we),
      .b_addr   (b_addr),
      .b_wdata  (b_wdata),
      .b_gnt    (b_gnt),
      .b_rvalid (b_rvalid),
      .b_rdata  (b_rdata),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: memory words, preferred requester, fill cycles left,
   // and the last read result seen by each requester.
   logic [15:0] m_mem [8];
   int          m_ptr;     // 0 = A preferred, 1 = B preferred
   int          m_init;
   logic [15:0] m_ard, m_brd;
   logic        m_arv, m_brv;
   logic        last_a_gnt, last_b_gnt;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ptr  = 0;
      m_init = 8;
      m_ard  = 16'd0;
      m_brd  = 16'd0;
      m_arv  = 1'b0;
      m_brv  = 1'b0;
   endtask

   // One clock cycle: drive, check grants mid-cycle, advance model at the edge,
   // then check read outputs just after the edge.
   task automatic step(input logic ar, input logic aw, input logic [2:0] aa, input logic [15:0] ad,
                       input logic br, input logic bw, input logic [2:0] ba, input logic [15:0] bd);
      logic eg_a, eg_b;
      a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
      b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
      @(negedge clk);
      eg_a = 1'b0;
      eg_b = 1'b0;
      if (m_init == 0) begin
         if (ar && br) begin
            eg_a = (m_ptr == 0);
            eg_b = (m_ptr == 1);
         end else begin
            eg_a = ar;
            eg_b = br;
         end
      end
      check("a_gnt", {15'd0, a_gnt}, {15'd0, eg_a});
      check("b_gnt", {15'd0, b_gnt}, {15'd0, eg_b});
      check("busy", {15'd0, busy}, {15'd0, (m_init != 0)});
      last_a_gnt = a_gnt;
      last_b_gnt = b_gnt;
      @(posedge clk);
      m_arv = 1'b0;
      m_brv = 1'b0;
      if (m_init != 0) begin
         m_mem[8 - m_init] = 16'd0;
         m_init--;
      end else if (eg_a) begin
         if (aw) m_mem[aa] = ad;
         else begin m_ard = m_mem[aa]; m_arv = 1'b1; end
         m_ptr = 1;
      end else if (eg_b) begin
         if (bw) m_mem[ba] = bd;
         else begin m_brd = m_mem[ba]; m_brv = 1'b1; end
         m_ptr = 0;
      end
      #1;
      check("a_rvalid", {15'd0, a_rvalid}, {15'd0, m_arv});
      check("b_rvalid", {15'd0, b_rvalid}, {15'd0, m_brv});
      check("a_rdata", a_rdata, m_ard);
      check("b_rdata", b_rdata, m_brd);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 3'd0, 16'd0);
   endtask

   typedef struct {
      logic        ar, aw; logic [2:0] aa; logic [15:0] ad;
      logic        br, bw; logic [2:0] ba; logic [15:0] bd;
      logic        exp_ag, exp_bg, exp_brv;
      logic [15:0] exp_brd;
   } vec_t;

   typedef struct {
      logic req, we; logic [2:0] addr; logic [15:0] d;
   } rq_t;

   vec_t tbl [4];
   rq_t  pa, pb;

   initial begin
      for (int i = 0; i < 8; i++) m_mem[i] = 16'hDEAD;
      rst_n = 1'b0;
      a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
      b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
      model_reset();

      // Contention table: A writes 3333 to addr 3, B reads addr 3, both every cycle.
      for (int i = 0; i < 4; i++) begin
         tbl[i].ar = 1; tbl[i].aw = 1; tbl[i].aa = 3'd3; tbl[i].ad = 16'd3333;
         tbl[i].br = 1; tbl[i].bw = 0; tbl[i].ba = 3'd3; tbl[i].bd = 16'd0;
         tbl[i].exp_ag  = (i % 2 == 0);
         tbl[i].exp_bg  = (i % 2 == 1);
         tbl[i].exp_brv = (i % 2 == 1);
         tbl[i].exp_brd = 16'd3333;
      end

      // Reset state while held.
      repeat (2) @(negedge clk);
      check("rst_busy", {15'd0, busy}, 16'd1);
      check("rst_a_gnt", {15'd0, a_gnt}, 16'd0);
      check("rst_a_rvalid", {15'd0, a_rvalid}, 16'd0);
      check("rst_b_rdata", b_rdata, 16'd0);
      @(posedge clk); #1 rst_n = 1'b1;

      // Fill: 8 busy cycles with both requesting, no grants.
      for (int i = 0; i < 8; i++) step(1, 0, 3'(i), 16'd0, 1, 0, 3'(i), 16'd0);
      check("fill_done_busy", {15'd0, busy}, 16'd0);
      // All words read back as the fill value.
      for (int i = 0; i < 8; i++) begin
         step(1, 0, 3'(i), 16'd0, 0, 0, 3'd0, 16'd0);
         check("fill_rd_val", a_rdata, 16'd0);
         check("fill_rd_vld", {15'd0, a_rvalid}, 16'd1);
      end

      // A write then read addr 1.
      step(1, 1, 3'd1, 16'd11111, 0, 0, 3'd0, 16'd0);
      step(1, 0, 3'd1, 16'd0, 0, 0, 3'd0, 16'd0);
      check("a_rd1_val", a_rdata, 16'd11111);
      check("a_rd1_vld", {15'd0, a_rvalid}, 16'd1);
      check("a_rd1_bvld", {15'd0, b_rvalid}, 16'd0);
      idle();
      check("a_rd1_pulse", {15'd0, a_rvalid}, 16'd0);

      // Pointer now prefers B; a lone A is still served, then contention goes to B.
      step(1, 1, 3'd6, 16'd66, 0, 0, 3'd0, 16'd0);
      check("lone_a_gnt", {15'd0, last_a_gnt}, 16'd1);
      step(1, 1, 3'd6, 16'd67, 1, 1, 3'd5, 16'd55);
      check("ptr_to_b_gnt", {15'd0, last_b_gnt}, 16'd1);

      // Pointer now prefers A for the table.
      foreach (tbl[i]) begin
         step(tbl[i].ar, tbl[i].aw, tbl[i].aa, tbl[i].ad, tbl[i].br, tbl[i].bw, tbl[i].ba, tbl[i].bd);
         check("tbl_a_gnt", {15'd0, last_a_gnt}, {15'd0, tbl[i].exp_ag});
         check("tbl_b_gnt", {15'd0, last_b_gnt}, {15'd0, tbl[i].exp_bg});
         check("tbl_b_rvalid", {15'd0, b_rvalid}, {15'd0, tbl[i].exp_brv});
         if (tbl[i].exp_brv) check("tbl_b_rdata", b_rdata, tbl[i].exp_brd);
      end

      // B fills every word with 21845, then A reads 7..0 back-to-back.
      for (int i = 0; i < 8; i++) begin
         step(0, 0, 3'd0, 16'd0, 1, 1, 3'(i), 16'd21845);
         check("b_fill_gnt", {15'd0, last_b_gnt}, 16'd1);
      end
      for (int i = 7; i >= 0; i--) begin
         step(1, 0, 3'(i), 16'd0, 0, 0, 3'd0, 16'd0);
         check("a_b2b_vld", {15'd0, a_rvalid}, 16'd1);
         check("a_b2b_val", a_rdata, 16'd21845);
      end

      // Random traffic; an ungranted request is held stable or withdrawn.
      pa = '{default: '0};
      pb = '{default: '0};
      for (int n = 0; n < 300; n++) begin
         if (!(pa.req && !last_a_gnt) || ($urandom_range(0, 7) == 0)) begin
            pa.req = $urandom_range(0, 1); pa.we = $urandom_range(0, 1);
            pa.addr = 3'($urandom_range(0, 7)); pa.d = 16'($urandom);
         end
         if (!(pb.req && !last_b_gnt) || ($urandom_range(0, 7) == 0)) begin
            pb.req = $urandom_range(0, 1); pb.we = $urandom_range(0, 1);
            pb.addr = 3'($urandom_range(0, 7)); pb.d = 16'($urandom);
         end
         step(pa.req, pa.we, pa.addr, pa.d, pb.req, pb.we, pb.addr, pb.d);
      end

      // Reset in the middle of an A read grant: read discarded, fill overwrites 7777.
      idle();
      step(1, 1, 3'd7, 16'd7777, 0, 0, 3'd0, 16'd0);
      a_req = 1; a_we = 0; a_addr = 3'd7; b_req = 0;
      @(negedge clk);
      check("mid_rd_gnt", {15'd0, a_gnt}, 16'd1);
      #2 rst_n = 1'b0;
      @(posedge clk); #1;
      check("mid_rst_rvalid", {15'd0, a_rvalid}, 16'd0);
      check("mid_rst_rdata", a_rdata, 16'd0);
      check("mid_rst_busy", {15'd0, busy}, 16'd1);
      a_req = 0;
      model_reset();
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) idle();
      step(1, 0, 3'd7, 16'd0, 0, 0, 3'd0, 16'd0);
      check("refill_addr7", a_rdata, 16'd0);
      check("refill_vld", {15'd0, a_rvalid}, 16'd1);
      idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Hard stop in case something stalls the sequence.
   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      n_fail++;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ram8_arbiter.md
RAM8_ARBITER -- requirements
Module: ram8_arbiter

Interface
REQ-001 Parameter CLEAR_ON_RESET, default 1: 1 runs the post-reset zero-fill of all 8 words; 0 skips it.
REQ-002 Parameter CLEAR_VAL, default 16'd0: value written to every word during zero-fill.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  input  1: the single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1: asynchronous active-low reset.
REQ-006 a_req  input  1: requester A access request.
REQ-007 a_we  input  1: A access type; 1 is write, 0 is read.
REQ-008 a_addr  input  3: A word address.
REQ-009 a_wdata  input  16: A write data.
REQ-010 a_gnt  output  1: A access accepted this cycle (combinational).
REQ-011 a_rvalid  output  1: A read data valid, one-cycle pulse.
REQ-012 a_rdata  output  16: A read data, held until the next A read completes.
REQ-013 b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: requester B, same widths and meanings as A.
REQ-014 busy  output  1: high while zero-fill runs; no grants are issued while high.

Function
REQ-015 FSM states: INIT (zero-fill) and RUN. Reset enters INIT if CLEAR_ON_RESET=1, otherwise RUN.
REQ-016 INIT behaviour:
- one write per cycle, addresses 0..7, data CLEAR_VAL, with RAM load=1;
- 8 cycles total, then RUN;
- busy=1 throughout, a_gnt=b_gnt=0.
REQ-017 RUN: at most one access per cycle; an access completes on the rising edge where req=1 and gnt=1.
REQ-018 Round-robin arbitration: a 1-bit pointer names the preferred requester; the pointer resets to A.
REQ-019 Only one requester asserts req: that requester is granted the same cycle.
REQ-020 Both requesters assert req: the preferred requester is granted and the other sees gnt=0.
REQ-021 After every grant the pointer moves to the other requester, so continuous dual requests alternate A,B,A,B.
REQ-022 A requester holds req, we, addr and wdata stable until it is granted; deasserting req before the grant withdraws the request.
REQ-023 Write on a granted cycle: RAM in=wdata, address=addr, load=1; the word updates at that edge.
REQ-024 Read on a granted cycle: RAM address=addr, load=0; the RAM output is registered into x_rdata at that edge, and x_rvalid=1 for exactly the following cycle.
REQ-025 Read latency is 1 cycle from grant to rvalid. Back-to-back reads by one requester give rvalid on consecutive cycles.
REQ-026 A write at edge N followed by a read of the same address granted at cycle N+1 returns the new data.
REQ-027 No grant in a cycle: RAM load=0 and the RAM address holds its previous value.
REQ-028 Addresses are 3 bits; every value 0..7 is legal and there is no wrap or out-of-range case.

Reset
REQ-029 rst_n low asynchronously clears:
- a_gnt, b_gnt, a_rvalid, b_rvalid to 0;
- a_rdata, b_rdata to 16'd0;
- pointer to A;
- INIT counter to 0;
- busy to CLEAR_ON_RESET.
REQ-030 Reset asserted mid-operation: any pending rvalid is discarded, an in-flight write is not guaranteed, and zero-fill restarts from address 0 on release.
REQ-031 RAM contents are not reset directly; they are defined only through zero-fill.

Structure
REQ-032 Shared package ram8_arbiter_pkg holds:
- DW=16, AW=3, DEPTH=8;
- FSM state encodings INIT and RUN;
- requester-select encoding A=0, B=1.
REQ-033 The block instantiates the existing RAM8 (16-bit, 8-word; ports in, load, address, clk, out) as its single sub-module.
REQ-034 Arbitration, the INIT counter and the read-data registers are in ram8_arbiter.

Verification
REQ-035 Reset release with CLEAR_ON_RESET=1 -> busy=1 for 8 cycles and no grants; then reads of all addresses 0..7 return 0.
REQ-036 A writes 11111 to address 1, then A reads address 1 -> a_rvalid pulses 1 cycle after the read grant with a_rdata=11111; b_rvalid stays 0.
REQ-037 A and B both request continuously for 4 cycles; A writes 3333 to address 3 and B reads address 3 -> grant order A,B,A,B; B's first read returns 3333.
REQ-038 B writes 21845 to addresses 0..7 back-to-back, then A reads addresses 7..0 -> 8 b_gnt cycles, then 8 a_rvalid pulses each carrying 21845.
REQ-039 rst_n pulsed low during an A read grant -> no a_rvalid follows, a_rdata=0, and zero-fill restarts and overwrites 7777 previously stored at address 7.
REQ-040 A requests with B idle while the pointer prefers B -> A granted the same cycle and the pointer moves to B.
